cpu_clock_ctrl: RTL and testbench

// - CPU clock-enable generator; sits directly upstream of Cpu. Replaces the raw

---
 rtl/cpu_clock_ctrl.sv | 102 ++++++++++
 tb/tb_cpu_clock_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: fast/slow divided enable, halt with single-step, LED heartbeat.
// Define CPU_CE_COUNT_EN to build the live 16-bit ce_count; otherwise ce_count is tied to zero.
module cpu_clock_ctrl #(
  parameter int FAST_PERIOD = 2,
  parameter int SLOW_PERIOD = 33554432,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_halt,
  input  logic        mode_slow,
  input  logic        step,
  output logic        cpu_ce,
  output logic        heartbeat,
  output logic [1:0]  state,
  output logic [15:0] ce_count
);

  typedef enum logic [1:0] {
    ST_FAST   = 2'b00,
    ST_SLOW   = 2'b01,
    ST_HALTED = 2'b10,
    ST_STEP   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(FAST_PERIOD - 1);
  localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(SLOW_PERIOD - 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] period_max;
  logic             step_q, step_edge;
  logic             run;
  logic             ce_d;

  // Handshake: cpu_ce is a one-clk strobe with no back-pressure; Cpu advances
  // on every cycle it is high and never stalls this block.
  always_comb begin
    step_edge  = step & ~step_q;
    nxt        = cur;
    period_max = (cur == ST_SLOW) ? SLOW_MAX : FAST_MAX;
    div_d      = '0;
    ce_d       = 1'b0;
    run        = 1'b0;

    if (mode_halt) begin
      nxt = (cur == ST_HALTED && step_edge) ? ST_STEP : ST_HALTED;
    end else begin
      case (cur)
        ST_STEP: nxt = ST_HALTED;
        default: nxt = mode_slow ? ST_SLOW : ST_FAST;
      endcase
    end

    // A state change restarts the divider, so no partial period carries over.
    run = (nxt == cur) && (cur == ST_FAST || cur == ST_SLOW);
    if (nxt == ST_STEP) begin
      ce_d = 1'b1;
    end else if (run) begin
      if (div_q == period_max) begin
        ce_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= ST_HALTED;
      div_q     <= '0;
      step_q    <= 1'b1;
      cpu_ce    <= 1'b0;
      heartbeat <= 1'b0;
    end else begin
      cur       <= nxt;
      div_q     <= div_d;
      step_q    <= step;
      cpu_ce    <= ce_d;
      heartbeat <= heartbeat ^ ce_d;
    end
  end

  assign state = cur;

`ifdef CPU_CE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else if (ce_d) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ce_count = cnt_q;
`else
  assign ce_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: directed stimulus pushes expected pulses,
// a negedge monitor pops and compares on every cpu_ce pulse.
module tb_cpu_clock_ctrl;

  localparam int W = 49;  // {cycle[31:0], heartbeat, ce_count[15:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode_halt, mode_slow, step;
  logic        cpu_ce, heartbeat;
  logic [1:0]  state;
  logic [15:0] ce_count;

  logic        w_halt, w_slow, w_step;
  logic        w_ce, w_hb;
  logic [1:0]  w_state;
  logic [15:0] w_count;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_clock_ctrl #(.FAST_PERIOD(2), .SLOW_PERIOD(8), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .mode_halt(mode_halt), .mode_slow(mode_slow),
    .step(step), .cpu_ce(cpu_ce), .heartbeat(heartbeat), .state(state),
    .ce_count(ce_count)
  );

  cpu_clock_ctrl #(.FAST_PERIOD(1), .SLOW_PERIOD(8), .CNT_W(26)) dut_wrap (
    .clk(clk), .rst(rst), .mode_halt(w_halt), .mode_slow(w_slow),
    .step(w_step), .cpu_ce(w_ce), .heartbeat(w_hb), .state(w_state),
    .ce_count(w_count)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_hb;
  logic [15:0]  exp_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] cnt_view(input logic [15:0] c);
`ifdef CPU_CE_COUNT_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  task automatic push_pulse(input int c);
    logic [W-1:0] e;
    exp_hb  = ~exp_hb;
    exp_cnt = exp_cnt + 16'd1;
    e = {32'(c), exp_hb, cnt_view(exp_cnt)};
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst === 1'b1 && cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e[48:17]));
        check("pulse_heartbeat", 64'(heartbeat), 64'(e[16]));
        check("pulse_ce_count", 64'(ce_count), 64'(e[15:0]));
      end
    end
  end

  // driver
  initial begin
    int t0, s, n;
    rst = 1'b0; mode_halt = 1'b1; mode_slow = 1'b0; step = 1'b0;
    w_halt = 1'b1; w_slow = 1'b0; w_step = 1'b0;
    exp_hb = 1'b0; exp_cnt = 16'h0000;

    // reset state, then 100 clk halted
    repeat (2) @(negedge clk);
    check("reset_state", 64'(state), 64'h2);
    check("reset_cpu_ce", 64'(cpu_ce), 64'h0);
    check("reset_heartbeat", 64'(heartbeat), 64'h0);
    check("reset_ce_count", 64'(ce_count), 64'h0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_halted_state", 64'(state), 64'h2);
    check("idle_ce_count", 64'(ce_count), 64'h0);

    // three steps 10 clk apart
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step = 1'b1;
      push_pulse(cyc + 1);
      @(negedge clk);
      check("step_state", 64'(state), 64'h3);
      step = 1'b0;
      @(negedge clk);
      check("after_step_state", 64'(state), 64'h2);
      repeat (7) @(negedge clk);
    end

    // back-to-back steps at the minimum 2 clk spacing
    @(negedge clk);
    n = cyc;
    step = 1'b1;
    push_pulse(n + 1);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    push_pulse(n + 3);
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);

    // fast mode for 20 clk, then switch to slow on a fast-pulse-due cycle
    @(negedge clk);
    t0 = cyc;
    mode_halt = 1'b0;
    mode_slow = 1'b0;
    for (int k = 0; k < 10; k++) push_pulse(t0 + 3 + 2 * k);
    wait_to(t0 + 2);
    check("fast_state", 64'(state), 64'h0);
    wait_to(t0 + 22);
    mode_slow = 1'b1;
    s = cyc;
    push_pulse(s + 9);
    push_pulse(s + 17);
    wait_to(s + 2);
    check("slow_state", 64'(state), 64'h1);
    // halt lands on the cycle the third slow pulse is due
    wait_to(s + 24);
    mode_halt = 1'b1;
    wait_to(s + 26);
    check("halt_state", 64'(state), 64'h2);
    wait_to(s + 40);
    check("queue_drained_before_reset", 64'(exp_q.size()), 64'h0);

    // step held high across reset release
    @(negedge clk);
    rst = 1'b0;
    step = 1'b1;
    exp_hb = 1'b0;
    exp_cnt = 16'h0000;
    repeat (2) @(negedge clk);
    check("rereset_ce_count", 64'(ce_count), 64'h0);
    check("rereset_heartbeat", 64'(heartbeat), 64'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("held_step_state", 64'(state), 64'h2);
    step = 1'b0;
    repeat (2) @(negedge clk);
    step = 1'b1;
    push_pulse(cyc + 1);
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);

    // ce_count wrap on a FAST_PERIOD=1 instance
    @(negedge clk);
    t0 = cyc;
    w_halt = 1'b0;
    wait_to(t0 + 2);
    check("wrap_state", 64'(w_state), 64'h0);
    check("wrap_first_ce", 64'(w_ce), 64'h1);
    check("wrap_first_count", 64'(w_count), 64'(cnt_view(16'h0001)));
    wait_to(t0 + 65536);
    check("wrap_count_ffff", 64'(w_count), 64'(cnt_view(16'hFFFF)));
    check("wrap_hb_odd", 64'(w_hb), 64'h1);
    wait_to(t0 + 65537);
    check("wrap_count_zero", 64'(w_count), 64'(cnt_view(16'h0000)));
    check("wrap_ce_continuous", 64'(w_ce), 64'h1);
    check("wrap_hb_even", 64'(w_hb), 64'h0);

    // final report
    check("missing_pulses", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
